// File: rtl/inta_if.sv
// inta_if: PIC-side handshake and result bus of the interrupt-acknowledge master.
interface inta_if;
  logic        int_i;
  logic        ien_i;
  logic        m8086_i;
  logic [7:0]  d_i;
  logic        rdy_i;
  logic        inta_o;
  logic        busy_o;
  logic [7:0]  vec_o;
  logic [15:0] addr_o;
  logic        vld_o;
  logic        err_o;
  modport master (
    input  int_i, ien_i, m8086_i, d_i, rdy_i,
    output inta_o, busy_o, vec_o, addr_o, vld_o, err_o
  );
  modport slave (
    output int_i, ien_i, m8086_i, d_i, rdy_i,
    input  inta_o, busy_o, vec_o, addr_o, vld_o, err_o
  );
endinterface

// File: rtl/inta_master.sv
// inta_master: issues 8086 (two-pulse) or 8080 (three-pulse) INTA sequences and captures the PIC response.
module inta_master #(
  parameter int PW = 2,
  parameter int GW = 1
) (
  input logic clk,
  input logic reset,
  inta_if.master bus
);
  typedef enum logic [1:0] {IDLE, PULSE, GAP, VALID} state_t;
  localparam logic [3:0] PW_M1 = 4'(PW - 1);
  localparam logic [3:0] GW_M1 = 4'(GW - 1);
  state_t      state_q, state_d;
  logic [1:0]  n_q, n_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        mode_q, mode_d;
  logic        inta_q, vld_q, err_q, err_d;
  logic [7:0]  vec_q, vec_d;
  logic [15:0] addr_q, addr_d;
  logic        last_pulse;
  // mode is latched at sequence start so mid-sequence m8086 changes are ignored
  assign last_pulse = n_q == (mode_q ? 2'd2 : 2'd3);
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    vec_d   = vec_q;
    addr_d  = addr_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (bus.int_i && bus.ien_i) begin
        state_d = PULSE;
        n_d     = 2'd1;
        cnt_d   = PW_M1;
        mode_d  = bus.m8086_i;
      end
      PULSE: if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
      else begin
        vec_d         = (mode_q && n_q == 2'd2) ? bus.d_i : vec_q;
        addr_d[7:0]   = (!mode_q && n_q == 2'd2) ? bus.d_i : addr_q[7:0];
        addr_d[15:8]  = (!mode_q && n_q == 2'd3) ? bus.d_i : addr_q[15:8];
        err_d         = !mode_q && n_q == 2'd1 && bus.d_i != 8'hCD;
        state_d       = last_pulse ? VALID : GAP;
        cnt_d         = last_pulse ? 4'd0 : GW_M1;
      end
      GAP: if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
      else begin
        state_d = PULSE;
        n_d     = n_q + 2'd1;
        cnt_d   = PW_M1;
      end
      VALID: if (bus.rdy_i) begin
        state_d = IDLE;
        n_d     = 2'd0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      n_q     <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      inta_q  <= 1'b0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      vec_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      inta_q  <= state_d == PULSE;
      vld_q   <= state_d == VALID;
      err_q   <= err_d;
      vec_q   <= vec_d;
      addr_q  <= addr_d;
    end
  end
  assign bus.inta_o = inta_q;
  assign bus.busy_o = state_q != IDLE;
  assign bus.vld_o  = vld_q;
  assign bus.err_o  = err_q;
  assign bus.vec_o  = vec_q;
  assign bus.addr_o = addr_q;
endmodule

// File: tb/tb_inta_master.sv
// tb_inta_master: directed checks of the INTA master with PW=2, GW=1.
module tb_inta_master;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;
  inta_if bus();
  inta_master #(.PW(2), .GW(1)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // starts a sequence from IDLE, then scrambles int/ien/mode after the first edge; records 10 cycles
  task automatic run_seq(input logic mode, input logic [7:0] p1, p2, p3,
                         output logic [9:0] ip, output logic [9:0] vp, output logic [9:0] ep);
    bus.m8086_i = mode;
    bus.int_i   = 1'b1;
    bus.ien_i   = 1'b1;
    bus.rdy_i   = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      bus.d_i = (k <= 3) ? p1 : (k <= 6) ? p2 : p3;
      tick();
      ip[10-k] = bus.inta_o;
      vp[10-k] = bus.vld_o;
      ep[10-k] = bus.err_o;
      if (k == 1) begin
        bus.int_i   = 1'b0;
        bus.ien_i   = 1'b0;
        bus.m8086_i = ~mode;
      end
    end
  endtask

  task automatic pulse_reset;
    #1 reset = 1'b1;
    #1 reset = 1'b0;
  endtask

  task automatic test_reset;
    logic bad;
    reset = 1'b0;
    bus.int_i = 1'b1; bus.ien_i = 1'b1; bus.m8086_i = 1'b1; bus.d_i = 8'hFF; bus.rdy_i = 1'b0;
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({bus.inta_o, bus.busy_o, bus.vld_o, bus.err_o, bus.vec_o, bus.addr_o} !== 28'h0) begin
      errors++;
      $display("FAIL reset_outputs: got inta=%b busy=%b vld=%b err=%b vec=%h addr=%h want all 0",
               bus.inta_o, bus.busy_o, bus.vld_o, bus.err_o, bus.vec_o, bus.addr_o);
    end
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      bad |= bus.inta_o | bus.busy_o | bus.vld_o;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL reset_held: got activity=%b want 0", bad);
    end
    reset = 1'b0;
    tick();
    checks++;
    if ({bus.inta_o, bus.busy_o} !== 2'b11) begin
      errors++;
      $display("FAIL reset_release_start: got inta,busy=%b want 11", {bus.inta_o, bus.busy_o});
    end
    bus.int_i = 1'b0;
    pulse_reset();
  endtask

  task automatic test_8086;
    logic [9:0] ip, vp, ep;
    run_seq(1'b1, 8'hAA, 8'h48, 8'h00, ip, vp, ep);
    checks++;
    if (ip !== 10'b1101100000) begin
      errors++;
      $display("FAIL m8086_inta: got %b want 1101100000", ip);
    end
    checks++;
    if (vp !== 10'b0000011111) begin
      errors++;
      $display("FAIL m8086_vld: got %b want 0000011111", vp);
    end
    checks++;
    if (ep !== 10'b0 || bus.vec_o !== 8'h48 || bus.addr_o !== 16'h0000) begin
      errors++;
      $display("FAIL m8086_data: got err=%b vec=%h addr=%h want 0 48 0000", ep, bus.vec_o, bus.addr_o);
    end
    bus.rdy_i = 1'b1;
    tick();
    bus.rdy_i = 1'b0;
    checks++;
    if ({bus.vld_o, bus.busy_o} !== 2'b00) begin
      errors++;
      $display("FAIL m8086_release: got vld,busy=%b want 00", {bus.vld_o, bus.busy_o});
    end
  endtask

  task automatic test_8080;
    logic [9:0] ip, vp, ep;
    run_seq(1'b0, 8'hCD, 8'h34, 8'h12, ip, vp, ep);
    checks++;
    if (ip !== 10'b1101101100) begin
      errors++;
      $display("FAIL m8080_inta: got %b want 1101101100", ip);
    end
    checks++;
    if (vp !== 10'b0000000011 || ep !== 10'b0) begin
      errors++;
      $display("FAIL m8080_vld_err: got vld=%b err=%b want 0000000011 0000000000", vp, ep);
    end
    checks++;
    if (bus.addr_o !== 16'h1234 || bus.vec_o !== 8'h48) begin
      errors++;
      $display("FAIL m8080_data: got addr=%h vec=%h want 1234 48", bus.addr_o, bus.vec_o);
    end
    bus.rdy_i = 1'b1;
    tick();
    bus.rdy_i = 1'b0;
  endtask

  task automatic test_err;
    logic [9:0] ip, vp, ep;
    run_seq(1'b0, 8'h00, 8'h78, 8'h56, ip, vp, ep);
    checks++;
    if (ep !== 10'b0010000000) begin
      errors++;
      $display("FAIL err_pulse: got %b want 0010000000", ep);
    end
    checks++;
    if (vp !== 10'b0000000011 || bus.addr_o !== 16'h5678) begin
      errors++;
      $display("FAIL err_completes: got vld=%b addr=%h want 0000000011 5678", vp, bus.addr_o);
    end
    bus.rdy_i = 1'b1;
    tick();
    bus.rdy_i = 1'b0;
  endtask

  task automatic test_ien_gate;
    logic bad;
    bus.int_i = 1'b1; bus.ien_i = 1'b0; bus.m8086_i = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      bad |= bus.inta_o | bus.busy_o;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL ien_gate: got activity=%b want 0", bad);
    end
    bus.ien_i = 1'b1;
    tick();
    checks++;
    if ({bus.inta_o, bus.busy_o} !== 2'b11) begin
      errors++;
      $display("FAIL ien_start: got inta,busy=%b want 11", {bus.inta_o, bus.busy_o});
    end
    bus.int_i = 1'b0;
    pulse_reset();
  endtask

  task automatic test_back_to_back;
    logic [9:0] ip, vp, ep;
    run_seq(1'b0, 8'hCD, 8'hBC, 8'h9A, ip, vp, ep);
    checks++;
    if (bus.addr_o !== 16'h9ABC || vp !== 10'b0000000011) begin
      errors++;
      $display("FAIL b2b_first: got addr=%h vld=%b want 9abc 0000000011", bus.addr_o, vp);
    end
    bus.int_i = 1'b1; bus.ien_i = 1'b1; bus.m8086_i = 1'b1; bus.rdy_i = 1'b1;
    tick();
    bus.rdy_i = 1'b0;
    checks++;
    if ({bus.vld_o, bus.busy_o, bus.inta_o} !== 3'b000) begin
      errors++;
      $display("FAIL b2b_idle_gap: got vld,busy,inta=%b want 000", {bus.vld_o, bus.busy_o, bus.inta_o});
    end
    tick();
    checks++;
    if ({bus.busy_o, bus.inta_o} !== 2'b11) begin
      errors++;
      $display("FAIL b2b_restart: got busy,inta=%b want 11", {bus.busy_o, bus.inta_o});
    end
    bus.int_i = 1'b0;
    pulse_reset();
  endtask

  task automatic test_hold_reset;
    logic [9:0] ip, vp, ep;
    logic bad;
    run_seq(1'b1, 8'h11, 8'h99, 8'h00, ip, vp, ep);
    bus.int_i = 1'b1; bus.ien_i = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      bad |= !bus.vld_o | bus.inta_o | (bus.vec_o != 8'h99);
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL hold_valid: got vld=%b inta=%b vec=%h want 1 0 99", bus.vld_o, bus.inta_o, bus.vec_o);
    end
    bus.rdy_i = 1'b1;
    tick();
    bus.rdy_i = 1'b0;
    checks++;
    if (bus.vld_o !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: got vld=%b want 0", bus.vld_o);
    end
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (bus.inta_o !== 1'b1) begin
      errors++;
      $display("FAIL pulse2_entry: got inta=%b want 1", bus.inta_o);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({bus.inta_o, bus.busy_o, bus.vld_o, bus.vec_o} !== 11'h0) begin
      errors++;
      $display("FAIL mid_reset: got inta=%b busy=%b vld=%b vec=%h want 0 0 0 00",
               bus.inta_o, bus.busy_o, bus.vld_o, bus.vec_o);
    end
    bus.int_i = 1'b0;
    #1 reset = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      bad |= bus.vld_o | bus.inta_o;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL post_abort: got activity=%b want 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_8086();
    test_8080();
    test_err();
    test_ien_gate();
    test_back_to_back();
    test_hold_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
